// File: rtl/uart_send.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serial shifter.
module uart_send #(
    parameter int unsigned CLK_FREQ   = 10_000_000,
    parameter int unsigned UART_BPS   = 128000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int unsigned CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTF_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNTF_W-1:0] count_q;
    logic              push;
    logic              pop;

    // Transmit FSM state
    state_e            state_q,   state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q,   shift_d;
    logic              txd_q,     txd_d;
    logic              done_q,    done_d;
    logic              busy_q;
    logic              bit_end;

    assign tx_ready   = (count_q != CNTF_W'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready;
    assign bit_end    = (clk_cnt_q == CNT_W'(BPS_CNT - 1));
    assign fifo_count = count_q;
    assign uart_txd   = txd_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

    // FIFO data write; contents need no reset since count gates every read
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNTF_W'(1);
                2'b01:   count_q <= count_q - CNTF_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM next-state, bit timing and line level
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        done_d    = 1'b0;
        pop       = 1'b0;

        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    txd_d     = 1'b0;
                    clk_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    txd_d     = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q != 3'd7) begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    if (count_q != '0) begin
                        // back-to-back frame: next start bit follows with no gap
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM registers; line forced idle-high the moment reset asserts
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

endmodule
